// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter. Sends one command byte to the device over
// the open-collector PS2_CLK/PS2_DAT pair: inhibit, request-to-send, 8 data
// bits LSB first, odd parity, stop, then check the device acknowledge.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout_err
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  typedef enum logic [2:0] {
    IDLE, INHIBIT, RTS, DATA, ACK, WAIT_IDLE
  } state_t;

  state_t      r_state;
  logic [7:0]  r_data;
  logic [19:0] r_cnt;
  logic [3:0]  r_bitcnt;
  logic        r_clk_prev;

  // index 0 = PS2_CLK, index 1 = PS2_DAT
  logic [1:0]  w_pad;
  logic [1:0]  w_filt;
  logic        w_clk_fall;
  logic        w_parity;

  assign w_pad      = {ps2_dat_in, ps2_clk_in};
  assign w_clk_fall = r_clk_prev & ~w_filt[0];
  assign w_parity   = ~^r_data;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_filt
      logic [1:0]    r_sync;
      logic          r_level;
      logic [FW-1:0] r_run;

      // Synchronise the pad, then accept a new level only after FILTER_LEN
      // consecutive samples disagree with the current one. Idle lines are high.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_sync  <= 2'b11;
          r_level <= 1'b1;
          r_run   <= '0;
        end else begin
          r_sync <= {r_sync[0], w_pad[gi]};
          if (r_sync[1] == r_level) begin
            r_run <= '0;
          end else if (r_run == FW'(FILTER_LEN - 1)) begin
            r_level <= r_sync[1];
            r_run   <= '0;
          end else begin
            r_run <= r_run + 1'b1;
          end
        end
      end

      assign w_filt[gi] = r_level;
    end
  endgenerate

  // Previous filtered clock level, for falling-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_clk_prev <= 1'b1;
    else      r_clk_prev <= w_filt[0];
  end

  // Transfer FSM with registered line enables and status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_data      <= '0;
      r_cnt       <= '0;
      r_bitcnt    <= '0;
      ps2_clk_oe  <= 1'b0;
      ps2_dat_oe  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ack_err     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          // busy drops here, one cycle after the done pulse
          busy       <= 1'b0;
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
          if (tx_start && !busy) begin
            r_data      <= tx_data;
            busy        <= 1'b1;
            r_cnt       <= '0;
            ack_err     <= 1'b0;
            timeout_err <= 1'b0;
            ps2_clk_oe  <= 1'b1;
            r_state     <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (r_cnt == 20'(INHIBIT_CYCLES - 1)) begin
            // start bit goes low in the same cycle the clock is released
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b1;
            r_cnt      <= '0;
            r_bitcnt   <= '0;
            r_state    <= RTS;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          // watchdog: restarted by every device clock edge, saturating
          if (w_clk_fall)          r_cnt <= '0;
          else if (r_cnt != '1)    r_cnt <= r_cnt + 1'b1;

          if (!w_clk_fall && r_cnt >= 20'(TIMEOUT_CYCLES - 1)) begin
            ps2_clk_oe  <= 1'b0;
            ps2_dat_oe  <= 1'b0;
            done        <= 1'b1;
            timeout_err <= 1'b1;
            ack_err     <= 1'b0;
            r_state     <= IDLE;
          end else begin
            case (r_state)
              RTS: begin
                if (w_clk_fall) begin
                  ps2_dat_oe <= ~r_data[0];
                  r_bitcnt   <= 4'd1;
                  r_state    <= DATA;
                end
              end
              DATA: begin
                if (w_clk_fall) begin
                  if (r_bitcnt <= 4'd7) begin
                    ps2_dat_oe <= ~r_data[r_bitcnt[2:0]];
                    r_bitcnt   <= r_bitcnt + 1'b1;
                  end else if (r_bitcnt == 4'd8) begin
                    ps2_dat_oe <= ~w_parity;
                    r_bitcnt   <= 4'd9;
                  end else begin
                    // stop bit: release DAT
                    ps2_dat_oe <= 1'b0;
                    r_state    <= ACK;
                  end
                end
              end
              ACK: begin
                if (w_clk_fall) begin
                  ack_err <= w_filt[1];
                  r_state <= WAIT_IDLE;
                end
              end
              WAIT_IDLE: begin
                if (w_filt[0] && w_filt[1]) begin
                  done    <= 1'b1;
                  r_state <= IDLE;
                end
              end
              default: r_state <= IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks the frame out of the
// host and a scoreboard of expected frames is compared against what it saw.
module tb_ps2_host_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       clk_line, dat_line;
  logic       ps2_clk_oe, ps2_dat_oe, busy, done, ack_err, timeout_err;

  int errors = 0;
  int checks = 0;

  // frame as seen by the device: bit0 start, 1..8 data, 9 parity, 10 stop
  logic [10:0] exp_q[$];

  always #5 clk = ~clk;

  assign clk_line = dev_clk & ~ps2_clk_oe;
  assign dat_line = dev_dat & ~ps2_dat_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(100),
    .TIMEOUT_CYCLES(2000),
    .FILTER_LEN(4)
  ) dut (
    .clk(clk), .rst(rst), .tx_start(tx_start), .tx_data(tx_data),
    .ps2_clk_in(clk_line), .ps2_dat_in(dat_line),
    .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe),
    .busy(busy), .done(done), .ack_err(ack_err), .timeout_err(timeout_err)
  );

  task automatic start_tx(input logic [7:0] b, input bit push);
    @(negedge clk);
    tx_data  = b;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    if (push) exp_q.push_back({1'b1, ~^b, b, 1'b0});
  endtask

  // Device side of one transfer. Returns the sampled frame, inhibit length
  // and whether DAT was already low when CLK was released.
  task automatic dev_xfer(input bit do_ack, input bit glitch, input bit poke,
                          input int abort_after, output logic [10:0] seen,
                          output int inh_len, output bit rts_ok);
    int n;
    seen = 'x;
    inh_len = 0;
    rts_ok = 1'b0;
    n = 0;
    while (!ps2_clk_oe && n < 50) begin @(negedge clk); n++; end
    while (ps2_clk_oe && inh_len < 1000) begin inh_len++; @(negedge clk); end
    rts_ok = ps2_dat_oe;
    repeat (30) @(negedge clk);
    seen[0] = dat_line;
    for (int i = 1; i <= 10; i++) begin
      dev_clk = 1'b0;
      if (poke && i == 3) begin
        @(negedge clk);
        tx_data  = 8'h12;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (18) @(negedge clk);
      end else begin
        repeat (20) @(negedge clk);
      end
      dev_clk = 1'b1;
      seen[i] = dat_line;
      if (i == abort_after) return;
      if (glitch && i == 4) begin
        repeat (5) @(negedge clk);
        dev_clk = 1'b0;
        repeat (3) @(negedge clk);
        dev_clk = 1'b1;
        repeat (12) @(negedge clk);
      end else if (i == 10) begin
        repeat (10) @(negedge clk);
        if (do_ack) dev_dat = 1'b0;
        repeat (10) @(negedge clk);
      end else begin
        repeat (20) @(negedge clk);
      end
    end
    dev_clk = 1'b0;
    repeat (20) @(negedge clk);
    dev_clk = 1'b1;
    repeat (5) @(negedge clk);
    dev_dat = 1'b1;
  endtask

  // Wait for done; capture flags, line enables and busy on the next cycle.
  task automatic wait_done(input int budget, output bit got, output logic ae,
                           output logic te, output logic [1:0] oe,
                           output logic busy_after, output logic done_after);
    int n = 0;
    while (!done && n < budget) begin @(negedge clk); n++; end
    got = done;
    ae = ack_err;
    te = timeout_err;
    oe = {ps2_clk_oe, ps2_dat_oe};
    @(negedge clk);
    busy_after = busy;
    done_after = done;
  endtask

  task automatic test_reset;
    logic [5:0] o;
    @(negedge clk);
    o = {ps2_clk_oe, ps2_dat_oe, busy, done, ack_err, timeout_err};
    checks++;
    if (o !== 6'b0) begin errors++; $display("FAIL reset_outputs got=%b want=000000", o); end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    o = {ps2_clk_oe, ps2_dat_oe, busy, done, ack_err, timeout_err};
    checks++;
    if (o !== 6'b0) begin errors++; $display("FAIL idle_outputs got=%b want=000000", o); end
    $display("test_reset outputs=%b", o);
  endtask

  // One complete acked transfer of byte b, compared against the scoreboard.
  task automatic test_xfer(input string name, input logic [7:0] b, input bit glitch);
    logic [10:0] seen, exp;
    int inh;
    bit rts_ok, got;
    logic ae, te, ba, da;
    logic [1:0] oe;
    start_tx(b, 1'b1);
    dev_xfer(1'b1, glitch, 1'b0, 0, seen, inh, rts_ok);
    wait_done(200, got, ae, te, oe, ba, da);
    exp = exp_q.pop_front();
    checks++;
    if (seen !== exp) begin errors++; $display("FAIL %s_frame got=%b want=%b", name, seen, exp); end
    checks++;
    if (inh !== 100) begin errors++; $display("FAIL %s_inhibit got=%0d want=100", name, inh); end
    checks++;
    if (rts_ok !== 1'b1) begin errors++; $display("FAIL %s_rts_dat got=%b want=1", name, rts_ok); end
    checks++;
    if ({got, ae, te} !== 3'b100) begin errors++; $display("FAIL %s_done_flags got=%b want=100", name, {got, ae, te}); end
    checks++;
    if ({ba, da, oe} !== 4'b0000) begin errors++; $display("FAIL %s_after got=%b want=0000", name, {ba, da, oe}); end
    $display("%s data=%02h frame=%b inhibit=%0d done=%b ack_err=%b timeout_err=%b", name, b, seen, inh, got, ae, te);
  endtask

  task automatic test_parity;
    logic [7:0] vals [3] = '{8'h01, 8'hFF, 8'h00};
    for (int k = 0; k < 3; k++) test_xfer("parity", vals[k], 1'b0);
  endtask

  task automatic test_ack_err;
    logic [10:0] seen;
    int inh;
    bit rts_ok, got;
    logic ae, te, ba, da;
    logic [1:0] oe;
    start_tx(8'hFF, 1'b0);
    dev_xfer(1'b0, 1'b0, 1'b0, 0, seen, inh, rts_ok);
    wait_done(200, got, ae, te, oe, ba, da);
    checks++;
    if ({got, ae, te} !== 3'b110) begin errors++; $display("FAIL ack_err_flags got=%b want=110", {got, ae, te}); end
    checks++;
    if ({oe, ba} !== 3'b000) begin errors++; $display("FAIL ack_err_release got=%b want=000", {oe, ba}); end
    $display("test_ack_err done=%b ack_err=%b timeout_err=%b oe=%b", got, ae, te, oe);
  endtask

  task automatic test_timeout;
    int n = 0;
    bit got;
    logic ae, te, ba, da;
    logic [1:0] oe;
    start_tx(8'hED, 1'b0);
    while (!ps2_clk_oe && n < 50) begin @(negedge clk); n++; end
    n = 0;
    while (ps2_clk_oe && n < 500) begin @(negedge clk); n++; end
    n = 0;
    while (!done && n < 3000) begin @(negedge clk); n++; end
    wait_done(0, got, ae, te, oe, ba, da);
    checks++;
    if (n !== 2000) begin errors++; $display("FAIL timeout_cycles got=%0d want=2000", n); end
    checks++;
    if ({got, ae, te} !== 3'b101) begin errors++; $display("FAIL timeout_flags got=%b want=101", {got, ae, te}); end
    checks++;
    if ({oe, ba} !== 3'b000) begin errors++; $display("FAIL timeout_release got=%b want=000", {oe, ba}); end
    $display("test_timeout cycles=%0d done=%b ack_err=%b timeout_err=%b oe=%b", n, got, ae, te, oe);
  endtask

  task automatic test_reset_mid;
    logic [10:0] seen, exp;
    int inh;
    bit rts_ok, got;
    logic ae, te, ba, da;
    logic [1:0] oe;
    logic [2:0] o;
    start_tx(8'hF4, 1'b0);
    dev_xfer(1'b1, 1'b0, 1'b0, 4, seen, inh, rts_ok);
    rst = 1'b0;
    #1;
    o = {ps2_clk_oe, ps2_dat_oe, busy};
    checks++;
    if (o !== 3'b000) begin errors++; $display("FAIL reset_mid_release got=%b want=000", o); end
    $display("test_reset_mid bits_before_reset=%b oe_busy=%b", seen[4:0], o);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    dev_clk = 1'b1;
    dev_dat = 1'b1;
    repeat (10) @(negedge clk);
    start_tx(8'hF4, 1'b1);
    dev_xfer(1'b1, 1'b0, 1'b1, 0, seen, inh, rts_ok);
    wait_done(200, got, ae, te, oe, ba, da);
    exp = exp_q.pop_front();
    checks++;
    if (seen !== exp) begin errors++; $display("FAIL after_reset_frame got=%b want=%b", seen, exp); end
    checks++;
    if ({got, ae, te} !== 3'b100) begin errors++; $display("FAIL after_reset_flags got=%b want=100", {got, ae, te}); end
    repeat (150) @(negedge clk);
    checks++;
    if ({busy, ps2_clk_oe, done} !== 3'b000) begin
      errors++; $display("FAIL busy_start_ignored got=%b want=000", {busy, ps2_clk_oe, done});
    end
    $display("test_after_reset data=f4 frame=%b done=%b ack_err=%b timeout_err=%b", seen, got, ae, te);
  endtask

  initial begin
    test_reset();
    test_xfer("basic_ed", 8'hED, 1'b0);
    test_parity();
    test_ack_err();
    test_timeout();
    test_reset_mid();
    test_xfer("glitch_a5", 8'hA5, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "time limit");
  end

endmodule
